// File: rtl/vga_timing_gen_if.sv
// Digit handshake between the game logic and vga_timing_gen.
//   digit_in    : BCD digit offered by the game logic
//   digit_valid : digit_in is valid
//   digit_ready : timing generator can take a digit this cycle
// master = game logic side, slave = timing generator side.
interface vga_timing_gen_if;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;

  modport master (
    output digit_in,
    output digit_valid,
    input  digit_ready
  );

  modport slave (
    input  digit_in,
    input  digit_valid,
    output digit_ready
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing plus a frame-synchronous digit latch.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   digit_if    : valid/ready digit handshake (slave side)
//   pix_tick    : one-clk pixel enable, every CLK_DIV clocks
//   h_counter   : horizontal position 0..H_TOTAL-1
//   v_counter   : vertical position 0..V_TOTAL-1
//   hsync/vsync : sync pulses, SYNC_ACTIVE level while asserted
//   video_on    : current pixel is in the visible area
//   frame_start : one-clk pulse when the counters become (0,0)
//   bcd_out     : committed digit; only changes on entry to vertical blanking
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.slave   digit_if,
  output logic              pix_tick,
  output logic [9:0]        h_counter,
  output logic [9:0]        v_counter,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              frame_start,
  output logic [3:0]        bcd_out
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast    = 10'(HTotal - 1);
  localparam logic [9:0]      VLast    = 10'(VTotal - 1);
  localparam logic [9:0]      HActive  = 10'(H_ACTIVE);
  localparam logic [9:0]      VActive  = 10'(V_ACTIVE);
  localparam logic [9:0]      VCommit  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]      HsStart  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]      HsEnd    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]      VsStart  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]      VsEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_d, v_d;
  logic            line_end, frame_end, commit, accept;
  logic            full_q;
  logic [3:0]      pending_q;

  always_comb begin
    div_d     = (div_q == DivLast) ? '0 : div_q + 1'b1;
    line_end  = pix_tick && (h_counter == HLast);
    frame_end = line_end && (v_counter == VLast);
    h_d       = h_counter;
    v_d       = v_counter;
    if (pix_tick) begin
      h_d = line_end ? 10'd0 : h_counter + 10'd1;
      if (line_end) begin
        v_d = (v_counter == VLast) ? 10'd0 : v_counter + 10'd1;
      end
    end
  end

  // Sync/blank flags decode the next counter values so they move on the same edge as the
  // counters; they only load on pixel ticks, so video_on stays low until the first tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      pix_tick    <= 1'b0;
      h_counter   <= 10'd0;
      v_counter   <= 10'd0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_q       <= div_d;
      pix_tick    <= (div_q == DivLast);
      h_counter   <= h_d;
      v_counter   <= v_d;
      frame_start <= frame_end;
      if (pix_tick) begin
        hsync    <= (h_d >= HsStart && h_d < HsEnd) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync    <= (v_d >= VsStart && v_d < VsEnd) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on <= (h_d < HActive) && (v_d < VActive);
      end
    end
  end

  // Single-entry digit slot. Commit only fires when the slot was already full before the
  // edge, so an accept on the commit edge waits for the next frame.
  assign digit_if.digit_ready = ~full_q;
  assign accept               = digit_if.digit_valid && ~full_q;
  assign commit               = line_end && (v_counter == VCommit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 1'b0;
      pending_q <= 4'd0;
      bcd_out   <= 4'd0;
    end else if (commit && full_q) begin
      bcd_out <= pending_q;
      full_q  <= 1'b0;
    end else if (accept && (digit_if.digit_in <= 4'd9)) begin
      // Non-BCD codes complete the handshake but are dropped.
      pending_q <= digit_if.digit_in;
      full_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  localparam int unsigned CD = 2;
  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME_CLK = HT * VT * CD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pix_tick, hsync, vsync, video_on, frame_start;
  logic [9:0] h_counter, v_counter;
  logic [3:0] bcd_out;

  vga_timing_gen_if dif ();

  vga_timing_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_if    (dif),
    .pix_tick    (pix_tick),
    .h_counter   (h_counter),
    .v_counter   (v_counter),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .frame_start (frame_start),
    .bcd_out     (bcd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  val;
    int unsigned due;
  } sb_t;

  typedef struct {
    logic [3:0] digit;
    logic       ready_after;
    logic [3:0] bcd_after;
  } vec_t;

  sb_t         sb[$];
  vec_t        vecs[6];
  logic [3:0]  exp_bcd = 4'd0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n = 0;
  int unsigned ccount = 0;

  // Clock edges since reset release, and commit edges seen so far.
  function automatic int unsigned moves(input int unsigned e);
    return (e == 0) ? 0 : (e - 1) / CD;
  endfunction

  function automatic bit is_commit_edge(input int unsigned e);
    int unsigned m;
    m = moves(e);
    return (e >= CD + 1) && ((e - 1) % CD == 0) && (m % HT == 0) && ((m / HT) % VT == VA);
  endfunction

  function automatic logic [24:0] model(input int unsigned e);
    int unsigned m, h, v;
    logic pt, hs, vs, vo, fs;
    m  = moves(e);
    h  = m % HT;
    v  = (m / HT) % VT;
    pt = (e >= CD) && (e % CD == 0);
    hs = !(h >= HA + HF && h < HA + HF + HS);
    vs = !(v >= VA + VF && v < VA + VF + VS);
    vo = (m > 0) && (h < HA) && (v < VA);
    fs = (m > 0) && (h == 0) && (v == 0) && ((e - 1) % CD == 0);
    return {pt, 10'(h), 10'(v), hs, vs, vo, fs};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  always @(posedge clk) begin
    if (rst_n && is_commit_edge(n + 1)) ccount <= ccount + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, got no event expected one at %0t", name, $time);
  endtask

  // Scoreboard monitor: retires a queued digit once its commit has happened, then checks
  // the raster outputs against the closed-form model and bcd_out against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due <= ccount) begin
      exp_bcd = sb[0].val;
      sb.delete(0);
    end
    check("timing", {7'd0, pix_tick, h_counter, v_counter, hsync, vsync, video_on, frame_start},
          {7'd0, model(n)});
    check("bcd_out", {28'd0, bcd_out}, {28'd0, exp_bcd});
  end

  // Call at a negedge; returns just after the accepting edge.
  task automatic offer(input logic [3:0] d, output int unsigned acc_edge);
    int unsigned cc;
    bit          done;
    sb_t         item;
    done     = 1'b0;
    acc_edge = 0;
    dif.digit_in    = d;
    dif.digit_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME_CLK && !done; i++) begin
      if (dif.digit_ready) begin
        acc_edge = n + 1;
        cc       = ccount;
        @(posedge clk);
        #1;
        dif.digit_valid = 1'b0;
        if (d <= 4'd9) begin
          item.val = d;
          item.due = is_commit_edge(acc_edge) ? cc + 2 : cc + 1;
          sb.push_back(item);
        end
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      dif.digit_valid = 1'b0;
      timeout("offer_accept");
    end
  endtask

  task automatic wait_line(input int unsigned vt);
    logic [24:0] mo;
    bit          found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
      @(negedge clk);
      mo = model(n);
      if (mo[23:14] == 10'd0 && mo[13:4] == 10'(vt)) found = 1'b1;
    end
    if (!found) timeout("wait_line");
  endtask

  // Leaves the bench at the negedge just before a commit edge.
  task automatic wait_pre_commit();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
      @(negedge clk);
      if (is_commit_edge(n + 1)) found = 1'b1;
    end
    if (!found) timeout("wait_commit");
  endtask

  initial begin
    int unsigned fs_cnt, per, e, e3, e5, c;
    bit          got;

    vecs[0] = '{digit: 4'd7,  ready_after: 1'b0, bcd_after: 4'd7};
    vecs[1] = '{digit: 4'd12, ready_after: 1'b1, bcd_after: 4'd7};
    vecs[2] = '{digit: 4'd0,  ready_after: 1'b0, bcd_after: 4'd0};
    vecs[3] = '{digit: 4'd9,  ready_after: 1'b0, bcd_after: 4'd9};
    vecs[4] = '{digit: 4'd15, ready_after: 1'b1, bcd_after: 4'd9};
    vecs[5] = '{digit: 4'd6,  ready_after: 1'b0, bcd_after: 4'd6};

    dif.digit_in    = 4'd0;
    dif.digit_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {7'd0, pix_tick, h_counter, v_counter, hsync, vsync, video_on,
          frame_start}, {7'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("reset_ready", 32'(dif.digit_ready), 32'd1);
    check("reset_bcd", {28'd0, bcd_out}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Two full frames: exactly two frame_start pulses.
    fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME_CLK + 2; i++) begin
      @(negedge clk);
      if (frame_start) fs_cnt++;
    end
    check("frame_start_count", 32'(fs_cnt), 32'd2);

    got = 1'b0;
    for (int i = 0; i < 4 * CD && !got; i++) begin
      @(negedge clk);
      if (pix_tick) got = 1'b1;
    end
    per = 0;
    got = 1'b0;
    for (int i = 0; i < 4 * CD && !got; i++) begin
      @(negedge clk);
      per++;
      if (pix_tick) got = 1'b1;
    end
    check("pix_tick_period", 32'(per), 32'(CD));

    // One digit per frame from the vector table.
    for (int i = 0; i < 6; i++) begin
      wait_line(2);
      offer(vecs[i].digit, e);
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 32'(dif.digit_ready), 32'(vecs[i].ready_after));
      wait_pre_commit();
      @(negedge clk);
      check($sformatf("vec%0d_bcd", i), {28'd0, bcd_out}, {28'd0, vecs[i].bcd_after});
      check($sformatf("vec%0d_ready_free", i), 32'(dif.digit_ready), 32'd1);
    end

    // 3 accepted, 5 held while full: 5 goes in on the edge after 3's commit.
    wait_line(2);
    offer(4'd3, e3);
    @(negedge clk);
    offer(4'd5, e5);
    c = e3 + 1;
    while (!is_commit_edge(c)) c++;
    check("held_accept_edge", e5, c + 1);
    @(negedge clk);
    check("held_first_commit", {28'd0, bcd_out}, 32'd3);
    wait_pre_commit();
    @(negedge clk);
    check("held_second_commit", {28'd0, bcd_out}, 32'd5);

    // Accept on the commit edge itself: lands next frame.
    wait_pre_commit();
    offer(4'd4, e);
    @(negedge clk);
    check("same_clk_bcd", {28'd0, bcd_out}, 32'd5);
    check("same_clk_ready", 32'(dif.digit_ready), 32'd0);
    wait_pre_commit();
    @(negedge clk);
    check("same_clk_next_frame", {28'd0, bcd_out}, 32'd4);

    // Mid-frame reset discards the pending digit.
    wait_line(2);
    offer(4'd8, e);
    wait_line(4);
    #2 rst_n = 1'b0;
    sb.delete();
    exp_bcd = 4'd0;
    #1;
    check("async_reset_outputs", {7'd0, pix_tick, h_counter, v_counter, hsync, vsync, video_on,
          frame_start}, {7'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("async_reset_bcd", {28'd0, bcd_out}, 32'd0);
    check("async_reset_ready", 32'(dif.digit_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_pre_commit();
    @(negedge clk);
    check("reset_pending_dropped", {28'd0, bcd_out}, 32'd0);
    check("reset_ready_after", 32'(dif.digit_ready), 32'd1);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
